// File: rtl/seg_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DATA_W     = 4 * NUM_DIGITS;

  localparam logic [7:0]            SEG_BLANK = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF   = 6'h3F;

  // Active-low gfedcba patterns, index 15 first.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef logic [DATA_W-1:0] digits_t;

endpackage

// File: rtl/seg_scan_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_scan_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_pattern
);

  assign o_pattern = SEG_FONT[i_nibble];

endmodule

// File: rtl/seg_scan.sv
// Six-digit common-anode scan driver with frame-aligned data transfer,
// dead-band anti-ghosting and leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = NUM_DIGITS,
  parameter logic [15:0] SCAN_MAX = 16'd50_000,
  parameter logic [15:0] DEAD     = 16'd500
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [NUM_DIGITS-1:0] i_point,
  input  logic                  i_lz_blank,
  input  logic                  i_en,
  output logic [NUM_DIGITS-1:0] o_sel,
  output logic [7:0]            o_seg,
  output logic                  o_frame_start
);

  localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [15:0]      CNT_TOP  = SCAN_MAX - 16'd1;
  localparam logic [15:0]      LIT_TOP  = SCAN_MAX - DEAD;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [15:0]           r_cnt;
  logic [IDX_W-1:0]      r_idx;
  digits_t               r_shd_data, r_act_data;
  logic [NUM_DIGITS-1:0] r_shd_point, r_act_point;
  logic                  r_shd_lz, r_act_lz, r_pending;

  logic                  w_boundary, w_dead, w_point, w_blank;
  logic [3:0]            w_nibble;
  logic [6:0]            w_font;
  logic [NUM_DIGITS-1:0] w_lz_mask, w_sel_d;
  logic [7:0]            w_seg_d;

  assign w_boundary = (r_cnt == '0) && (r_idx == IDX_LAST);
  assign w_dead     = (r_cnt >= LIT_TOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CNT_TOP;
      r_idx <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= CNT_TOP;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // A load on the boundary cycle lands in shadow after active took the old shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shd_data  <= '0;
      r_shd_point <= '0;
      r_shd_lz    <= 1'b0;
      r_act_data  <= '0;
      r_act_point <= '0;
      r_act_lz    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_act_data  <= r_shd_data;
        r_act_point <= r_shd_point;
        r_act_lz    <= r_shd_lz;
        r_pending   <= 1'b0;
      end
      if (i_load) begin
        r_shd_data  <= i_data;
        r_shd_point <= i_point;
        r_shd_lz    <= i_lz_blank;
        r_pending   <= 1'b1;
      end
    end
  end

  // Digit i is blanked when it and every digit above it hold zero.
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero_above = v_zero_above & (r_act_data[4*i +: 4] == 4'h0);
      w_lz_mask[i] = r_act_lz && v_zero_above && (i != 0);
    end
  end

  always_comb begin
    w_nibble = '0;
    w_point  = 1'b0;
    w_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble = r_act_data[4*i +: 4];
        w_point  = r_act_point[i];
        w_blank  = w_lz_mask[i];
      end
    end
  end

  seg_scan_decode u_decode (
    .i_nibble  (w_nibble),
    .o_pattern (w_font)
  );

  always_comb begin
    w_sel_d = SEL_OFF;
    w_seg_d = SEG_BLANK;
    if (i_en && !w_dead) begin
      w_sel_d = ~(NUM_DIGITS'(1) << r_idx);
      w_seg_d = {~w_point, w_blank ? 7'h7F : w_font};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sel         <= SEL_OFF;
      o_seg         <= SEG_BLANK;
      o_frame_start <= 1'b0;
    end else begin
      o_sel         <= w_sel_d;
      o_seg         <= w_seg_d;
      o_frame_start <= w_boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized bench for seg_scan against a cycle-count based display model.
module tb_seg_scan;

  localparam int SCAN  = 8;
  localparam int DEADC = 2;
  localparam int NDIG  = 6;
  localparam int FRAME = SCAN * NDIG;

  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [23:0] data = '0;
  logic [5:0]  point = '0;
  logic        lz = 1'b0;
  logic        en = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        fs;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_k counts clock edges since reset release.
  int          m_k;
  logic [23:0] m_sd, m_ad;
  logic [5:0]  m_sp, m_ap;
  logic        m_sl, m_al, m_pend;

  seg_scan #(
    .DIGITS   (NDIG),
    .SCAN_MAX (16'(SCAN)),
    .DEAD     (16'(DEADC))
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_load        (load),
    .i_data        (data),
    .i_point       (point),
    .i_lz_blank    (lz),
    .i_en          (en),
    .o_sel         (sel),
    .o_seg         (seg),
    .o_frame_start (fs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, m_k, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [23:0] d, input logic [5:0] p,
                                         input logic l, input int dig);
    int         hi;
    logic [3:0] nib;
    logic [7:0] s;
    hi = 0;
    for (int i = 0; i < NDIG; i++) if (((d >> (4 * i)) & 24'hF) != 0) hi = i;
    nib = 4'((d >> (4 * dig)) & 24'hF);
    s = FONT[nib];
    if (l && dig > hi) s = 8'hFF;
    s[7] = ~p[dig];
    return s;
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_sd = '0; m_ad = '0; m_sp = '0; m_ap = '0;
    m_sl = 1'b0; m_al = 1'b0; m_pend = 1'b0;
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, compare.
  task automatic tick();
    logic [5:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fs, c_load, c_lz;
    logic [23:0] c_data;
    logic [5:0]  c_point;
    int          dig;
    dig = (m_k / SCAN) % NDIG;
    if (en && (m_k % SCAN) >= DEADC) begin
      e_sel = ~(6'b1 << dig);
      e_seg = ref_seg(m_ad, m_ap, m_al, dig);
    end else begin
      e_sel = 6'h3F;
      e_seg = 8'hFF;
    end
    e_fs    = (m_k % FRAME) == FRAME - 1;
    c_load  = load;
    c_data  = data;
    c_point = point;
    c_lz    = lz;
    @(posedge clk);
    if (e_fs && m_pend) begin
      m_ad = m_sd; m_ap = m_sp; m_al = m_sl; m_pend = 1'b0;
    end
    if (c_load) begin
      m_sd = c_data; m_sp = c_point; m_sl = c_lz; m_pend = 1'b1;
    end
    m_k++;
    #2;
    check_eq("sel", 32'(sel), 32'(e_sel));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("frame_start", 32'(fs), 32'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int frame_pos);
    for (int i = 0; i < FRAME && (m_k % FRAME) != frame_pos; i++) tick();
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic l);
    data = d; point = p; lz = l; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset_sel", 32'(sel), 32'h3F);
    check_eq("reset_seg", 32'(seg), 32'hFF);
    check_eq("reset_fs", 32'(fs), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Idle after reset: digit 0 lights at cycle DEAD+1 showing "0".
    run(100);

    // Mid-frame load, visible from the next boundary.
    run_to(20);
    do_load(24'h123456, 6'b000100, 1'b0);
    run(120);

    // Leading-zero blanking.
    do_load(24'h000070, 6'b000000, 1'b1);
    run(110);
    do_load(24'h000000, 6'b000000, 1'b1);
    run(110);

    // Load on the boundary cycle then one cycle later: A never shown.
    do_load(24'h654321, 6'b100001, 1'b0);
    run(60);
    run_to(FRAME - 1);
    do_load(24'hAAAAAA, 6'b111111, 1'b0);
    do_load(24'hB0C0DE, 6'b010000, 1'b0);
    run(150);

    // Enable gating mid-frame.
    run_to(13);
    en = 1'b0;
    run(30);
    en = 1'b1;
    run(100);

    // Random loads and enable toggling.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) begin
        data  = 24'($urandom() >> (4 * $urandom_range(0, 6)));
        point = 6'($urandom());
        lz    = 1'($urandom());
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    en = 1'b1;
    run(FRAME + 4);

    // Asynchronous reset during a lit slot of digit 1.
    run_to(SCAN + 4);
    check_eq("lit_before_reset", 32'(sel == 6'h3F), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_sel", 32'(sel), 32'h3F);
    check_eq("async_seg", 32'(seg), 32'hFF);
    check_eq("async_fs", 32'(fs), 32'h0);
    @(posedge clk);
    #2;
    check_eq("hold_sel", 32'(sel), 32'h3F);
    rst_n = 1'b1;
    model_reset();
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
